// File: rtl/data_mem_be_pipe.sv
// Single-port data memory with per-byte write enables and a request/response
// pipeline. After reset an optional sweep zero-fills every word; requests are
// only accepted once the sweep has finished. Responses come back 1 cycle after
// acceptance, or 2 cycles with the optional output register.
module data_mem_be_pipe #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_ADDR_BITS  = 9,
    parameter int OUT_REG        = 0,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [RAM_WIDTH/8-1:0]   req_byte_en,
    input  logic [RAM_ADDR_BITS-1:0] req_addr,
    input  logic [RAM_WIDTH-1:0]     req_wdata,
    output logic                     rsp_valid,
    output logic [RAM_WIDTH-1:0]     rsp_data,
    output logic                     busy
);

    localparam int NUM_BYTES = RAM_WIDTH / 8;
    localparam int DEPTH     = 2 ** RAM_ADDR_BITS;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [RAM_ADDR_BITS-1:0] clr_addr;
    logic                     clr_last;
    logic                     accept;

    // Memory port, shared between the clear sweep and normal writes.
    logic                     mem_we;
    logic [NUM_BYTES-1:0]     mem_be;
    logic [RAM_ADDR_BITS-1:0] mem_addr;
    logic [RAM_WIDTH-1:0]     mem_wdata;
    logic [NUM_BYTES-1:0][7:0] mem [DEPTH];

    // First response stage: raw RAM word plus the write bytes needed to
    // rebuild the merged word when write-first responses are selected.
    logic                     s1_valid;
    logic [RAM_WIDTH-1:0]     rd_word;
    logic [NUM_BYTES-1:0]     s1_mask;
    logic [RAM_WIDTH-1:0]     s1_wdata;
    logic [RAM_WIDTH-1:0]     s1_data;

    assign clr_last = (clr_addr == {RAM_ADDR_BITS{1'b1}});
    assign accept   = req_valid && req_ready;

    // State register: reset lands in CLEAR (sweep) or straight in RUN.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave CLEAR right after the last address is written.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_last) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // FSM outputs: busy while sweeping, ready only in RUN and out of reset.
    always_comb begin
        busy      = (state == ST_CLEAR);
        req_ready = (state == ST_RUN) && !reset;
    end

    // Sweep address counter; saturates on the last word instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR && !clr_last) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Memory port mux: the sweep owns the port while busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (busy && !reset) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = clr_addr;
            mem_wdata = '0;
        end else if (accept && req_write) begin
            mem_we = 1'b1;
            mem_be = req_byte_en;
        end
    end

    // Byte-enabled RAM write.
    // NOTE: the array itself is never reset, so it maps onto block RAM; the
    // clear sweep provides zero contents instead.
    always_ff @(posedge clock) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (mem_we && mem_be[b]) begin
                mem[mem_addr][b] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Registered RAM read; returns the pre-write word on a write.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_word <= '0;
        end else if (accept) begin
            rd_word <= mem[mem_addr];
        end
    end

    // Stage-1 control: valid pulse and the write bytes for the merged view.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mask  <= '0;
            s1_wdata <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_mask  <= (WRITE_FIRST != 0 && req_write) ? req_byte_en : '0;
                s1_wdata <= req_wdata;
            end
        end
    end

    // Merge: written bytes override the old word for write-first responses.
    always_comb begin
        s1_data = rd_word;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (s1_mask[b]) s1_data[8*b +: 8] = s1_wdata[8*b +: 8];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                 out_valid;
            logic [RAM_WIDTH-1:0] out_data;

            // Output register: adds one cycle and holds data between pulses.
            always_ff @(posedge clock) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else begin
                    out_valid <= s1_valid;
                    if (s1_valid) out_data <= s1_data;
                end
            end

            assign rsp_valid = out_valid;
            assign rsp_data  = out_data;
        end else begin : g_no_out_reg
            assign rsp_valid = s1_valid;
            assign rsp_data  = s1_data;
        end
    endgenerate

endmodule
